// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message-schedule sequencer.
package sha256_pkg;

  localparam int unsigned W_LENGTH_DEFAULT = 64;
  localparam int unsigned W_LOAD_WORDS     = 16;
  localparam int unsigned IDX_W            = $clog2(W_LENGTH_DEFAULT) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait16,
    StExpand,
    StRound,
    StDone
  } w_sched_state_t;

  // States in which the loader/expander datapath is clocked.
  function automatic logic loader_active(input w_sched_state_t s);
    return (s == StLoad) || (s == StWait16) || (s == StExpand);
  endfunction

endpackage

// File: rtl/w_sched_ctrl.sv
// Sequencer for the SHA-256 message schedule: loads 16 words, expands to W_LENGTH,
// then streams round indices to the compression engine. Every output is a flop.
module w_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned W_LENGTH = W_LENGTH_DEFAULT,
  localparam int unsigned IdxW = $clog2(W_LENGTH) + 1,
  localparam int unsigned RndW = $clog2(W_LENGTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            abort,
  input  logic            blk_valid,
  input  logic            last_block,
  output logic            blk_ready,
  output logic            w_enable,
  output logic [IdxW-1:0] w_vector_index,
  output logic            w_index_complete,
  input  logic            w_16_complete,
  output logic            round_valid,
  input  logic            round_ready,
  output logic [RndW-1:0] round_index,
  output logic            hash_init,
  output logic            digest_valid,
  output logic            busy
);

  localparam logic [IdxW-1:0] LastLoadIdx  = IdxW'(W_LOAD_WORDS - 1);
  localparam logic [IdxW-1:0] FirstExpIdx  = IdxW'(W_LOAD_WORDS);
  localparam logic [IdxW-1:0] LastWordIdx  = IdxW'(W_LENGTH - 1);
  localparam logic [RndW-1:0] LastRoundIdx = RndW'(W_LENGTH - 1);

  w_sched_state_t  state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [RndW-1:0] ridx_q, ridx_d;
  logic            first_q, first_d;
  logic            last_q, last_d;

  logic            blk_ready_q, blk_ready_d;
  logic            w_enable_q, w_enable_d;
  logic            w_index_complete_q, w_index_complete_d;
  logic            round_valid_q, round_valid_d;
  logic            hash_init_q, hash_init_d;
  logic            digest_valid_q, digest_valid_d;
  logic            busy_q, busy_d;

  logic            blk_hs;
  logic            rnd_hs;

  // blk_ready_q gates the handshake so the cycle right after reset accepts nothing.
  assign blk_hs = (state_q == StIdle) && blk_ready_q && blk_valid && !abort;
  assign rnd_hs = round_valid_q && round_ready;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    ridx_d         = ridx_q;
    first_d        = first_q;
    last_d         = last_q;
    hash_init_d    = 1'b0;
    digest_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (blk_hs) begin
          last_d      = last_block;
          hash_init_d = first_q;
          first_d     = 1'b0;
          idx_d       = '0;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        if (idx_q == LastLoadIdx) begin
          state_d = StWait16;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StWait16: begin
        if (w_16_complete) begin
          idx_d   = FirstExpIdx;
          state_d = StExpand;
        end
      end
      StExpand: begin
        if (idx_q == LastWordIdx) begin
          ridx_d  = '0;
          state_d = StRound;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StRound: begin
        if (rnd_hs) begin
          if (ridx_q == LastRoundIdx) begin
            // Pulse is generated on entry so it is visible during the DONE cycle.
            digest_valid_d = last_q;
            if (last_q) begin
              first_d = 1'b1;
            end
            state_d = StDone;
          end else begin
            ridx_d = ridx_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort) begin
      state_d        = StIdle;
      hash_init_d    = 1'b0;
      digest_valid_d = 1'b0;
      first_d        = 1'b1;
    end

    if (state_d == StIdle) begin
      idx_d = '0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    blk_ready_d        = (state_d == StIdle);
    busy_d             = (state_d != StIdle);
    w_enable_d         = loader_active(state_d);
    w_index_complete_d = (state_d == StExpand) || (state_d == StRound) || (state_d == StDone);
    round_valid_d      = (state_d == StRound);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q            <= StIdle;
      idx_q              <= '0;
      ridx_q             <= '0;
      first_q            <= 1'b1;
      last_q             <= 1'b0;
      blk_ready_q        <= 1'b0;
      w_enable_q         <= 1'b0;
      w_index_complete_q <= 1'b0;
      round_valid_q      <= 1'b0;
      hash_init_q        <= 1'b0;
      digest_valid_q     <= 1'b0;
      busy_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      ridx_q             <= ridx_d;
      first_q            <= first_d;
      last_q             <= last_d;
      blk_ready_q        <= blk_ready_d;
      w_enable_q         <= w_enable_d;
      w_index_complete_q <= w_index_complete_d;
      round_valid_q      <= round_valid_d;
      hash_init_q        <= hash_init_d;
      digest_valid_q     <= digest_valid_d;
      busy_q             <= busy_d;
    end
  end

  assign blk_ready        = blk_ready_q;
  assign w_enable         = w_enable_q;
  assign w_vector_index   = idx_q;
  assign w_index_complete = w_index_complete_q;
  assign round_valid      = round_valid_q;
  assign round_index      = ridx_q;
  assign hash_init        = hash_init_q;
  assign digest_valid     = digest_valid_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_w_sched_ctrl.sv
// Directed bench for w_sched_ctrl: per-cycle expected output vectors derived from the
// block timeline (load, wait16, expand, rounds with optional stalls, done).
module tb_w_sched_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       abort = 1'b0;
  logic       blk_valid = 1'b0;
  logic       last_block = 1'b0;
  logic       w_16_complete = 1'b0;
  logic       round_ready = 1'b0;
  logic       blk_ready, w_enable, w_index_complete, round_valid, hash_init, digest_valid, busy;
  logic [6:0] w_vector_index;
  logic [5:0] round_index;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  w_sched_ctrl #(.W_LENGTH(64)) dut (
    .clock            (clock),
    .reset            (reset),
    .abort            (abort),
    .blk_valid        (blk_valid),
    .last_block       (last_block),
    .blk_ready        (blk_ready),
    .w_enable         (w_enable),
    .w_vector_index   (w_vector_index),
    .w_index_complete (w_index_complete),
    .w_16_complete    (w_16_complete),
    .round_valid      (round_valid),
    .round_ready      (round_ready),
    .round_index      (round_index),
    .hash_init        (hash_init),
    .digest_valid     (digest_valid),
    .busy             (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // {busy, blk_ready, w_enable, w_index_complete, round_valid, hash_init, digest_valid,
  //  w_vector_index[6:0], round_index[5:0]}
  function automatic logic [31:0] pack_out();
    return {12'b0, busy, blk_ready, w_enable, w_index_complete, round_valid, hash_init,
            digest_valid, w_vector_index, round_index};
  endfunction

  function automatic logic [31:0] mk(input bit bz, input bit br, input bit we, input bit wic,
                                     input bit rv, input bit hi, input bit dv,
                                     input int idx, input int ridx);
    return {12'b0, bz, br, we, wic, rv, hi, dv, 7'(idx), 6'(ridx)};
  endfunction

  localparam logic [31:0] IdleMask = 32'hFFFF_FFC0;

  task automatic check_idle(input string tag);
    check(tag, pack_out() & IdleMask, mk(0, 1, 0, 0, 0, 0, 0, 0, 0) & IdleMask);
  endtask

  // Runs one block from handshake. kill_at > 0 ends it early at that cycle by abort
  // (kill_rst=0) or by an asynchronous reset pulse (kill_rst=1).
  task automatic do_block(input string tag, input bit last, input bit hi_exp, input bit dv_exp,
                          input int d, input int stall_at, input int stall_len,
                          input int kill_at, input bit kill_rst);
    int w = 0;
    int e0, r0, done, rcnt, stalled;
    while (!blk_ready && w < 20) begin
      tick();
      w++;
    end
    check({tag, "_ready"}, 32'(blk_ready), 32'd1);
    if (!blk_ready) return;
    blk_valid  = 1'b1;
    last_block = last;
    tick();
    blk_valid  = 1'b0;
    last_block = ~last;
    e0 = 18 + d;
    r0 = e0 + 48;
    done = r0 + 64 + stall_len;
    rcnt = 0;
    stalled = 0;
    for (int c = 1; c <= done + 1; c++) begin
      logic [31:0] e, m;
      w_16_complete = (c == 17 + d);
      round_ready = 1'b1;
      if (c >= r0 && c < done && rcnt == stall_at && stalled < stall_len) begin
        round_ready = 1'b0;
        stalled++;
      end
      if (c <= 16)        e = mk(1, 0, 1, 0, 0, (c == 1) && hi_exp, 0, c - 1, 0);
      else if (c < e0)    e = mk(1, 0, 1, 0, 0, 0, 0, 15, 0);
      else if (c < r0)    e = mk(1, 0, 1, 1, 0, 0, 0, 16 + c - e0, 0);
      else if (c < done)  e = mk(1, 0, 0, 1, 1, 0, 0, 0, rcnt);
      else if (c == done) e = mk(1, 0, 0, 1, 0, 0, dv_exp, 0, 0);
      else                e = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
      m = 32'hFFFF_FFFF;
      if (!(c >= r0 && c < done)) m[5:0] = 6'd0;
      if (c >= r0 && c <= done)   m[12:6] = 7'd0;
      check($sformatf("%s_c%0d", tag, c), pack_out() & m, e & m);
      if (c == kill_at) begin
        if (kill_rst) begin
          #2 reset = 1'b1;
          #1 check({tag, "_async_rst"}, pack_out(), 32'd0);
          #1 reset = 1'b0;
          tick();
          check_idle({tag, "_rst_release"});
        end else begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          check_idle({tag, "_abort_idle"});
        end
        w_16_complete = 1'b0;
        round_ready = 1'b0;
        return;
      end
      tick();
      if (c >= r0 && c < done && round_ready) rcnt++;
    end
    w_16_complete = 1'b0;
    round_ready = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("reset_outputs", pack_out(), 32'd0);
    reset = 1'b0;
    tick();
    check_idle("ready_after_reset");

    do_block("single", 1, 1, 1, 0, -1, 0, 0, 0);

    do_block("msg2_b1", 0, 1, 0, 0, -1, 0, 0, 0);
    do_block("msg2_b2", 1, 0, 1, 0, -1, 0, 0, 0);
    do_block("msg3", 1, 1, 1, 0, -1, 0, 0, 0);

    do_block("stall", 1, 1, 1, 0, 10, 5, 0, 0);
    do_block("w16dly", 1, 1, 1, 3, -1, 0, 0, 0);

    do_block("pre_abort", 0, 1, 0, 0, -1, 0, 0, 0);
    do_block("abort", 1, 0, 0, 0, -1, 0, 32, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("post_abort_idle%0d", i));
    end
    // A handshake attempted together with abort must be ignored.
    abort = 1'b1;
    blk_valid = 1'b1;
    tick();
    abort = 1'b0;
    blk_valid = 1'b0;
    check_idle("abort_blocks_hs");
    tick();
    check_idle("abort_blocks_hs2");
    do_block("after_abort", 1, 1, 1, 0, -1, 0, 0, 0);

    do_block("pre_rst", 0, 1, 0, 0, -1, 0, 0, 0);
    do_block("rst_mid", 0, 0, 0, 0, -1, 0, 90, 1);
    do_block("after_rst", 1, 1, 1, 0, -1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
